spi_bus_arb: RTL
================

// Module: spi_bus_arb
// PURPOSE
//  Arbitrates one shared SPI master between two requesters: the inertial sensor interface
//  (port 0, high priority) and the A2D interface (port 1). Sits between those blocks and the
//  SPI master. Sequences each transaction: grant, issue, wait for done, return the response,
//  then enforce a bus gap. Drives a one-hot slave-select steer so SS_n reaches the right device.
// PARAMETERS
//  MAX_CONSEC   4      back-to-back port-0 grants allowed while port 1 is pending (1..15)
//  GAP_CYCLES   2      idle cycles after every transaction before the next grant (1..15)
//  TIMEOUT_CYC  4096   cycles in WAIT before abort (used only with SPI_ARB_TIMEOUT_EN)
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous active-low reset
//  req0      in   1   port 0 request; held high until done0
//  cmd0      in   16  port 0 SPI command word; stable while req0 is high
//  done0     out  1   one-cycle pulse: port 0 transaction complete
//  rsp0      out  16  port 0 read data; valid from done0, held until the next done0
//  err0      out  1   qualifies done0: transaction aborted
//  req1/cmd1/done1/rsp1/err1   same as port 0, for port 1
//  wrt       out  1   one-cycle pulse to the SPI master: start a transaction
//  cmd       out  16  command word to the SPI master; registered, held until the next wrt
//  spi_done  in   1   one-cycle pulse from the SPI master: transaction finished
//  rd_data   in   16  SPI master read data; valid with spi_done
//  ss_sel    out  2   one-hot slave steer (01 = port 0, 10 = port 1, 00 = none)
//  busy      out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; consec counter 0. Reset mid-transaction drops the
//   transaction with no done pulse. The SPI master shares rst_n.
//  FSM: IDLE -> ISSUE -> WAIT -> GAP -> IDLE.
//   IDLE: no req -> stay. Otherwise pick a winner, latch cmd_x into cmd, set ss_sel -> ISSUE.
//   ISSUE: wrt=1 for exactly this cycle -> WAIT.
//   WAIT: on spi_done, rsp_x<=rd_data and done_x=1 the next cycle, err_x=0 -> GAP.
//   GAP: ss_sel=00; count GAP_CYCLES cycles -> IDLE.
//  Latency: req seen in IDLE at cycle N -> wrt at N+1; spi_done at M -> done_x at M+1.
//  Priority: port 0 wins ties, unless port 1 is pending and consec==MAX_CONSEC, in which
//   case port 1 wins. consec increments on each port-0 grant (saturating) and clears on
//   any port-1 grant or when port 1 is idle at grant time.
//  Requester drops req while granted: the transaction still completes and done_x still
//   pulses. A new req is not honoured until the arbiter is back in IDLE.
//  spi_done outside WAIT: ignored. cmd_x changes after grant: ignored, because cmd is latched.
//  done0 and done1 are never high in the same cycle.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined:
//   - A 16-bit counter runs in WAIT.
//   - At TIMEOUT_CYC cycles with no spi_done: done_x=1, err_x=1, rsp_x=16'hFFFF -> GAP.
//   - A spi_done arriving later is ignored.
//  Not defined: no counter; WAIT waits indefinitely; err0 and err1 are tied 0.
// STRUCTURE
//  spi_arb_pkg: state enum {IDLE,ISSUE,WAIT,GAP}, SS_NONE/SS_P0/SS_P1 encodings,
//   16-bit word width constant.
//  One sub-module, spi_arb_pick: combinational winner select, plus the consec counter
//   with its MAX_CONSEC starvation rule. The FSM and datapath stay in spi_bus_arb.
// TESTING
//  1 Single port-0 req, cmd0=16'hA5A5; model replies rd_data=16'h1234 3 cycles after wrt
//    -> wrt at N+1, cmd=A5A5, ss_sel=01, done0 pulse, rsp0=1234, then ss_sel=00 for 2 cycles.
//  2 req0 and req1 rise in the same cycle -> port 0 granted first, then port 1 after the gap;
//    done0 and done1 never coincide.
//  3 req0 held continuously, req1 pending -> exactly 4 port-0 grants, then a port-1 grant,
//    then consec restarts.
//  4 req1 drops in WAIT -> done1 still pulses, rsp1=rd_data, and no second grant to port 1.
//  5 rst_n asserted in WAIT -> all outputs 0 asynchronously; after release, IDLE and no done.
//  6 (SPI_ARB_TIMEOUT_EN) spi_done withheld -> done0=1, err0=1, rsp0=FFFF exactly 4096 cycles
//    after entering WAIT; a late spi_done is ignored.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and encodings for the two-port SPI bus arbiter.
package spi_arb_pkg;
  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  localparam logic [1:0] SS_NONE = 2'b00;
  localparam logic [1:0] SS_P0   = 2'b01;
  localparam logic [1:0] SS_P1   = 2'b10;
endpackage

// File: rtl/spi_arb_pick.sv
// Winner select for the SPI arbiter. Port 0 has priority. Port 1 is forced through
// after MAX_CONSEC back-to-back port-0 grants that happen while port 1 is waiting.
module spi_arb_pick #(
  parameter int MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic grant,
  output logic pick1
);
  logic [3:0] consec;
  logic       starve;

  assign starve = (consec == 4'(MAX_CONSEC));
  assign pick1  = req1 & (~req0 | starve);

  // Count port-0 grants that skip a waiting port 1; any port-1 grant or an idle port 1 restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      consec <= '0;
    else if (grant) begin
      if (pick1 || !req1)
        consec <= '0;
      else if (!starve)
        consec <= consec + 4'd1;
    end
  end
endmodule

// File: rtl/spi_bus_arb.sv
// Two-port arbiter in front of a single SPI master.
// Sequence per transaction: IDLE (grant) -> ISSUE (wrt) -> WAIT (spi_done) -> GAP -> IDLE.
// Optional build macro SPI_ARB_TIMEOUT_EN: abort WAIT after TIMEOUT_CYC cycles with err set
// and rsp forced to FFFF. Without it WAIT has no bound and err0/err1 are constant 0.
module spi_bus_arb
  import spi_arb_pkg::*;
#(
  parameter int MAX_CONSEC  = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] cmd0,
  output logic        done0,
  output logic [15:0] rsp0,
  output logic        err0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        done1,
  output logic [15:0] rsp1,
  output logic        err1,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        spi_done,
  input  logic [15:0] rd_data,
  output logic [1:0]  ss_sel,
  output logic        busy
);
  state_t     state, nxt;
  logic       owner;
  logic [3:0] gap_cnt;
  logic       grant, pick1, spi_ok, tmo, fin;

  assign grant  = (state == IDLE) && (req0 || req1);
  assign spi_ok = (state == WAIT) && spi_done;
  assign fin    = spi_ok || tmo;

  spi_arb_pick #(.MAX_CONSEC(MAX_CONSEC)) u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .grant (grant),
    .pick1 (pick1)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic [1:0]  err_q;

  assign tmo  = (state == WAIT) && !spi_done && (tmo_cnt == 16'(TIMEOUT_CYC - 1));
  assign err0 = err_q[0];
  assign err1 = err_q[1];

  // Cycles spent in WAIT; restarts every time WAIT is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (state == WAIT)
      tmo_cnt <= tmo_cnt + 16'd1;
    else
      tmo_cnt <= '0;
  end

  // Error flag travels with the done pulse and holds until that port's next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= '0;
    else if (fin) begin
      if (owner) err_q[1] <= tmo;
      else       err_q[0] <= tmo;
    end
  end
`else
  assign tmo  = 1'b0;
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req0 || req1) nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    if (fin) nxt = GAP;
      GAP:     if (gap_cnt == 4'(GAP_CYCLES - 1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    wrt  = (state == ISSUE);
    busy = (state != IDLE);
  end

  // Datapath: latch the winner's command at grant, return the response at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= '0;
      ss_sel  <= SS_NONE;
      owner   <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rsp0    <= '0;
      rsp1    <= '0;
      gap_cnt <= '0;
    end else begin
      done0   <= 1'b0;
      done1   <= 1'b0;
      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (grant) begin
        cmd    <= pick1 ? cmd1 : cmd0;
        ss_sel <= pick1 ? SS_P1 : SS_P0;
        owner  <= pick1;
      end
      if (fin) begin
        ss_sel <= SS_NONE;
        if (owner) begin
          done1 <= 1'b1;
          rsp1  <= tmo ? 16'hFFFF : rd_data;
        end else begin
          done0 <= 1'b1;
          rsp0  <= tmo ? 16'hFFFF : rd_data;
        end
      end
    end
  end
endmodule
